// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS data memory: size codes, FSM states,
// and the big-endian byte-lane helpers.
package mips_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Enable bit 3 drives bits [31:24]; address offset 0 maps there (big-endian).
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
    byte_en = 4'b0000;
    case (size)
      SZ_BYTE: byte_en = 4'b1000 >> lo;
      SZ_HALF: byte_en = lo[1] ? 4'b0011 : 4'b1100;
      SZ_WORD: byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  endfunction

  // Replicate right-aligned store data so every enabled lane sees the right bits.
  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
    store_data = wdata;
    case (size)
      SZ_BYTE: store_data = {4{wdata[7:0]}};
      SZ_HALF: store_data = {2{wdata[15:0]}};
      default: store_data = wdata;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] lo, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[31:24];
    case (lo)
      2'd0: b = word[31:24];
      2'd1: b = word[23:16];
      2'd2: b = word[15:8];
      default: b = word[7:0];
    endcase
    h = lo[1] ? word[15:0] : word[31:16];
    case (size)
      SZ_BYTE: load_extract = uns ? {24'd0, b} : {{24{b[7]}}, b};
      SZ_HALF: load_extract = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: load_extract = word;
    endcase
  endfunction

endpackage

// File: rtl/mem_sram_be.sv
// Word-wide storage with per-byte write enables and a registered read port.
module mem_sram_be #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic [3:0]    i_we,
  input  logic          i_re,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  // Contents start at zero at power-up and are deliberately not touched by reset.
  logic [31:0] r_mem [DEPTH_WORDS] = '{default: '0};
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (i_we[l]) r_mem[i_addr][8*l +: 8] <= i_wdata[8*l +: 8];
    end
    if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_memory_hs.sv
// MIPS data memory with valid/ready request and response channels,
// configurable read latency and alignment/range error detection.
module data_memory_hs
  import mips_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS  = 256,
  parameter int          READ_LATENCY = 1,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic [1:0]  dbg_state
);

  localparam int         AW     = $clog2(DEPTH_WORDS);
  localparam logic [2:0] LAT_M1 = 3'(READ_LATENCY - 1);

  // Handshake: a transfer happens on any edge where valid && ready on that
  // channel; a producer holds valid and payload stable until it transfers.
  state_t      r_state, w_next;
  logic [2:0]  r_cnt;
  logic        r_write, r_uns, r_err;
  logic [1:0]  r_size, r_lo;

  logic          w_accept, w_err, w_in_range, w_misalign, w_re;
  logic [31:0]   w_off, w_wdata, w_rword;
  logic [3:0]    w_we;
  logic [AW-1:0] w_index;

  assign w_accept   = req_valid && (r_state == IDLE);
  assign w_off      = req_addr - BASE_ADDR;
  // Addresses below the base wrap to a huge offset and fail this test too.
  assign w_in_range = (w_off >> (AW + 2)) == 32'd0;
  assign w_misalign = ((req_size == SZ_HALF) && req_addr[0]) ||
                      ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
  assign w_err      = !w_in_range || w_misalign || (req_size == 2'b11);
  assign w_index    = w_off[AW+1:2];
  assign w_we       = (w_accept && req_write && !w_err) ? byte_en(req_size, req_addr[1:0]) : 4'b0000;
  assign w_re       = w_accept && !req_write && !w_err;
  assign w_wdata    = store_data(req_size, req_wdata);

  mem_sram_be #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_sram (
    .clk     (clk),
    .i_we    (w_we),
    .i_re    (w_re),
    .i_addr  (w_index),
    .i_wdata (w_wdata),
    .o_rdata (w_rword)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = (READ_LATENCY > 1) ? WAIT : RESP;
      WAIT:    if (r_cnt == 3'd1) w_next = RESP;
      RESP:    if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= 3'd0;
      r_write <= 1'b0;
      r_size  <= SZ_BYTE;
      r_uns   <= 1'b0;
      r_lo    <= 2'b00;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_cnt   <= LAT_M1;
      r_write <= req_write;
      r_size  <= req_size;
      r_uns   <= req_unsigned;
      r_lo    <= req_addr[1:0];
      r_err   <= w_err;
    end else if (r_state == WAIT) begin
      r_cnt   <= r_cnt - 3'd1;
    end
  end

  // The SRAM output only changes on a load accept, so it stays stable through RESP.
  assign req_ready = (r_state == IDLE);
  assign rsp_valid = (r_state == RESP);
  assign rsp_error = (r_state == RESP) && r_err;
  assign rsp_rdata = ((r_state == RESP) && !r_write && !r_err) ?
                     load_extract(w_rword, r_size, r_lo, r_uns) : 32'd0;
  assign dbg_state = r_state;

endmodule
